// File: rtl/rv_regfile_pkg.sv
// rv_regfile_pkg: shared widths, write-back source tags and request layout for the regfile write port.
package rv_regfile_pkg;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;
    localparam int NUM_REGS = 32;
    typedef enum logic {WB_ALU = 1'b0, WB_LSU = 1'b1} wb_src_e;
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_DATA_WIDTH-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; priority flips only on cycles where both sources request.
module rr_arb2
    import rv_regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    wb_src_e prio;
    always_ff @(posedge clk) begin
        if (rst) prio <= WB_ALU;
        else if (&req) prio <= gnt[WB_ALU] ? WB_LSU : WB_ALU;
    end
    always_comb begin
        gnt = '0;
        gnt[WB_ALU] = req[WB_ALU] && (!req[WB_LSU] || prio == WB_ALU);
        gnt[WB_LSU] = req[WB_LSU] && (!req[WB_ALU] || prio == WB_LSU);
    end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: arbitrates ALU/LSU write-back onto the regfile port and tracks outstanding loads.
// Optional REGFILE_WB_BYPASS_EN adds r1_fwd/r2_fwd so decode can forward from the write-back stage.
module regfile_wb_ctrl #(
    parameter int ADDR_W   = rv_regfile_pkg::REG_ADDR_WIDTH,
    parameter int DATA_W   = rv_regfile_pkg::REG_DATA_WIDTH,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_long,
    output logic              issue_stall,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [ADDR_W-1:0] r2_addr,
    output logic              r1_busy,
    output logic              r2_busy,
`ifdef REGFILE_WB_BYPASS_EN
    output logic              r1_fwd,
    output logic              r2_fwd,
`endif
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_write_en
);
    rv_regfile_pkg::wb_req_t sel, wb_q;
    logic [1:0]          gnt;
    logic [NUM_REGS-1:0] pending, pending_d;
    logic                set_pend, wb_hit1, wb_hit2;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({lsu_valid, alu_valid}),
        .gnt (gnt)
    );

    assign alu_ready  = gnt[rv_regfile_pkg::WB_ALU];
    assign lsu_ready  = gnt[rv_regfile_pkg::WB_LSU];
    assign sel        = lsu_ready ? {lsu_rd, lsu_data} : {alu_rd, alu_data};
    assign rf_rd_addr = wb_q.rd;
    assign rf_rd_data = wb_q.data;

    assign issue_stall = issue_valid && pending[issue_rd];
    assign set_pend    = issue_valid && issue_long && !issue_stall && issue_rd != '0;

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        pending_d = pending;
        if (lsu_ready) pending_d[lsu_rd] = 1'b0;
        if (set_pend) pending_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= '0;
            rf_write_en <= 1'b0;
            wb_q        <= '0;
        end else begin
            pending     <= pending_d;
            rf_write_en <= (|gnt) && sel.rd != '0;
            if (|gnt) wb_q <= sel;
        end
    end

    assign wb_hit1 = rf_write_en && rf_rd_addr == r1_addr;
    assign wb_hit2 = rf_write_en && rf_rd_addr == r2_addr;

`ifdef REGFILE_WB_BYPASS_EN
    assign r1_fwd  = r1_addr != '0 && wb_hit1;
    assign r2_fwd  = r2_addr != '0 && wb_hit2;
    assign r1_busy = r1_addr != '0 && pending[r1_addr];
    assign r2_busy = r2_addr != '0 && pending[r2_addr];
`else
    assign r1_busy = r1_addr != '0 && (pending[r1_addr] || wb_hit1);
    assign r2_busy = r2_addr != '0 && (pending[r2_addr] || wb_hit2);
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed plus random stimulus checked every cycle against a behavioural model.
module tb_regfile_wb_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, issue_valid, issue_long, issue_stall, r1_busy, r2_busy;
    logic alu_valid, alu_ready, lsu_valid, lsu_ready, rf_write_en;
    logic [4:0] issue_rd, r1_addr, r2_addr, alu_rd, lsu_rd, rf_rd_addr;
    logic [31:0] alu_data, lsu_data, rf_rd_data;
`ifdef REGFILE_WB_BYPASS_EN
    logic r1_fwd, r2_fwd;
`endif

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_long(issue_long), .issue_stall(issue_stall),
        .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_busy(r1_busy), .r2_busy(r2_busy),
`ifdef REGFILE_WB_BYPASS_EN
        .r1_fwd(r1_fwd), .r2_fwd(r2_fwd),
`endif
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_write_en(rf_write_en)
    );

    bit        d_rst, d_iv, d_il, d_av, d_lv;
    bit [4:0]  d_ird, d_a1, d_a2, d_ard, d_lrd;
    bit [31:0] d_ad, d_ld;

    bit        pend [32];
    bit        m_en, lsu_next;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit busy_exp(input bit [4:0] a);
`ifdef REGFILE_WB_BYPASS_EN
        return a != 0 && pend[a];
`else
        return a != 0 && (pend[a] || (m_en && m_addr == a));
`endif
    endfunction

    task automatic idle();
        {d_rst, d_iv, d_il, d_av, d_lv} = '0;
        {d_ird, d_a1, d_a2, d_ard, d_lrd} = '0;
        d_ad = 0; d_ld = 0;
    endtask

    task automatic tick();
        bit ar, lr, st;
        @(negedge clk);
        rst = d_rst; issue_valid = d_iv; issue_long = d_il; issue_rd = d_ird;
        r1_addr = d_a1; r2_addr = d_a2;
        alu_valid = d_av; alu_rd = d_ard; alu_data = d_ad;
        lsu_valid = d_lv; lsu_rd = d_lrd; lsu_data = d_ld;
        #1;
        ar = d_av && (!d_lv || !lsu_next);
        lr = d_lv && (!d_av || lsu_next);
        st = d_iv && pend[d_ird];
        chk("alu_ready", alu_ready, ar);
        chk("lsu_ready", lsu_ready, lr);
        chk("issue_stall", issue_stall, st);
        chk("r1_busy", r1_busy, busy_exp(d_a1));
        chk("r2_busy", r2_busy, busy_exp(d_a2));
`ifdef REGFILE_WB_BYPASS_EN
        chk("r1_fwd", r1_fwd, d_a1 != 0 && m_en && m_addr == d_a1);
        chk("r2_fwd", r2_fwd, d_a2 != 0 && m_en && m_addr == d_a2);
`endif
        chk("rf_write_en", rf_write_en, m_en);
        if (m_en) begin
            chk("rf_rd_addr", rf_rd_addr, m_addr);
            chk("rf_rd_data", rf_rd_data, m_data);
        end
        if (d_rst) begin
            pend = '{default: 0};
            m_en = 0; m_addr = 0; m_data = 0; lsu_next = 0;
        end else begin
            if (d_av && d_lv) lsu_next = ar;
            m_en = 0;
            if (ar || lr) begin
                m_addr = lr ? d_lrd : d_ard;
                m_data = lr ? d_ld : d_ad;
                m_en = m_addr != 0;
            end
            if (lr) pend[d_lrd] = 0;
            if (d_iv && d_il && !st && d_ird != 0) pend[d_ird] = 1;
        end
    endtask

    initial begin
        idle(); d_rst = 1; tick(); tick();
        idle(); tick();
        chk("reset_en", rf_write_en, 0);
        chk("reset_addr", rf_rd_addr, 0);
        chk("reset_data", rf_rd_data, 0);

        idle(); d_av = 1; d_ard = 5; d_ad = 32'h1234; tick();
        chk("alu_x5_ready", alu_ready, 1);
        idle(); tick();
        chk("alu_x5_en", rf_write_en, 1);
        chk("alu_x5_addr", rf_rd_addr, 5);
        chk("alu_x5_data", rf_rd_data, 32'h1234);

        idle(); d_av = 1; d_lv = 1; d_ard = 1; d_lrd = 2; d_ad = 32'hA; d_ld = 32'hB; tick();
        chk("rr0_alu", alu_ready, 1); chk("rr0_lsu", lsu_ready, 0);
        tick();
        chk("rr1_alu", alu_ready, 0); chk("rr1_lsu", lsu_ready, 1);
        tick();
        chk("rr2_alu", alu_ready, 1); chk("rr2_lsu", lsu_ready, 0);

        idle(); d_iv = 1; d_il = 1; d_ird = 7; tick();
        chk("x7_issue_stall", issue_stall, 0);
        idle(); d_a1 = 7; tick();
        chk("x7_busy", r1_busy, 1);
        d_iv = 1; d_il = 1; d_ird = 7; tick();
        chk("x7_waw_stall", issue_stall, 1);
        idle(); d_a1 = 7; d_lv = 1; d_lrd = 7; d_ld = 32'hBEEF; tick();
        chk("x7_lsu_ready", lsu_ready, 1);
        chk("x7_busy_on_return", r1_busy, 1);
        idle(); d_a1 = 7; tick();
        chk("x7_wb_en", rf_write_en, 1);
        chk("x7_wb_addr", rf_rd_addr, 7);
        chk("x7_wb_data", rf_rd_data, 32'hBEEF);
`ifdef REGFILE_WB_BYPASS_EN
        chk("x7_busy_wb", r1_busy, 0);
        chk("x7_fwd", r1_fwd, 1);
`else
        chk("x7_busy_wb", r1_busy, 1);
`endif
        tick();
        chk("x7_busy_done", r1_busy, 0);

        idle(); d_lv = 1; d_lrd = 9; d_ld = 32'h99; d_iv = 1; d_il = 1; d_ird = 9; tick();
        chk("x9_lsu_ready", lsu_ready, 1);
        idle(); d_a1 = 9; tick(); tick();
        chk("x9_still_pending", r1_busy, 1);
        d_lv = 1; d_lrd = 9; tick();
        idle(); tick(); tick();

        idle(); d_av = 1; d_ard = 0; d_ad = 32'hFFFF; tick();
        chk("x0_ready", alu_ready, 1);
        chk("x0_busy", r1_busy, 0);
        idle(); tick();
        chk("x0_no_write", rf_write_en, 0);

        idle(); d_iv = 1; d_il = 1; d_ird = 3; d_av = 1; d_ard = 4; d_ad = 32'h44; tick();
        idle(); d_rst = 1; d_a1 = 3; d_a2 = 4; tick();
        chk("pre_rst_en", rf_write_en, 1);
        chk("pre_rst_busy", r1_busy, 1);
        idle(); d_a1 = 3; d_a2 = 4; tick();
        chk("post_rst_en", rf_write_en, 0);
        chk("post_rst_busy1", r1_busy, 0);
        chk("post_rst_busy2", r2_busy, 0);
        idle(); d_av = 1; d_lv = 1; d_ard = 1; d_lrd = 2; tick();
        chk("post_rst_alu_first", alu_ready, 1);
        chk("post_rst_lsu_wait", lsu_ready, 0);

        for (int c = 0; c < 3000; c++) begin
            idle();
            d_rst = ($urandom_range(0, 127) == 0);
            d_iv = $urandom_range(0, 1); d_il = $urandom_range(0, 1); d_ird = 5'($urandom_range(0, 9));
            d_a1 = 5'($urandom_range(0, 9)); d_a2 = 5'($urandom_range(0, 9));
            d_av = ($urandom_range(0, 2) != 0); d_ard = 5'($urandom_range(0, 9)); d_ad = $urandom;
            d_lv = ($urandom_range(0, 2) == 0); d_lrd = 5'($urandom_range(0, 31)); d_ld = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                int s = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++)
                    if (pend[(s + k) % 32]) begin d_lrd = 5'((s + k) % 32); break; end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-back controller for the 32x32 register file's single write port.
- Arbitrates between two write-back sources:
  - the single-cycle ALU result path;
  - the variable-latency load/store unit (LSU) result path.
- Keeps a per-register pending scoreboard for outstanding loads.
- Tells decode when a source or destination register is not yet safe to use.
- Sits between execute/LSU and the regfile write port; decode consumes its hazard outputs.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- issue_valid  in  1  decode is issuing an instruction this cycle.
- issue_rd  in  ADDR_W  destination register of the issuing instruction.
- issue_long  in  1  issuing instruction is a load (result arrives via LSU).
- issue_stall  out  1  WAW hazard: issue_rd already has a pending load.
- r1_addr  in  ADDR_W  decode source register 1.
- r2_addr  in  ADDR_W  decode source register 2.
- r1_busy  out  1  source 1 not yet readable from the regfile.
- r2_busy  out  1  source 2 not yet readable from the regfile.
- alu_valid  in  1  ALU result available.
- alu_rd  in  ADDR_W  ALU destination.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- lsu_valid  in  1  load result available.
- lsu_rd  in  ADDR_W  load destination.
- lsu_data  in  DATA_W  load result.
- lsu_ready  out  1  load result accepted this cycle.
- rf_rd_addr  out  ADDR_W  regfile write address.
- rf_rd_data  out  DATA_W  regfile write data.
- rf_write_en  out  1  regfile write enable.

Behaviour:
- Reset (rst=1 at posedge):
  - all pending bits cleared;
  - write-back stage invalid: rf_write_en=0, rf_rd_addr=0, rf_rd_data=0;
  - round-robin pointer set to ALU-first.
  - Reset mid-operation discards any in-flight write and all pending state.
- Handshake:
  - A transfer occurs when valid && ready.
  - ready is combinational from valid and the arbitration pointer.
  - The regfile never back-pressures, so at least one valid source is always granted.
- Arbitration (two-way round-robin):
  - Single valid source is always granted.
  - Both valid: grant goes to the source not granted on the most recent contended cycle.
  - Pointer updates only on contended cycles.
- Latency:
  - An accepted request is registered into the write-back stage.
  - rf_write_en/addr/data are valid on the cycle after acceptance.
  - The regfile commits at the end of that cycle, so the total is 2 edges from acceptance to visibility.
- x0 handling:
  - Requests with rd=0 are accepted (ready asserted) but produce rf_write_en=0.
  - Issues with rd=0 never set a pending bit.
- Scoreboard (pending[NUM_REGS]):
  - Set on issue_valid && issue_long && !issue_stall && issue_rd!=0.
  - Cleared on lsu_valid && lsu_ready for lsu_rd.
  - Same register set and cleared in the same cycle: set wins.
- issue_stall = issue_valid && pending[issue_rd]. This applies to both short and long instructions.
- rX_busy = (rX_addr!=0) && (pending[rX_addr] || wb_stage_match(rX_addr)).
  - wb_stage_match means rf_write_en=1 and rf_rd_addr equals the source address.
  - It is cleared when WB_BYPASS_EN is defined (see Optional Feature).
- LSU write to a non-pending register: written normally; no error.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - adds outputs r1_fwd and r2_fwd (1 bit each), each = (rX_addr!=0) && wb_stage_match(rX_addr);
  - decode muxes rf_rd_data on a forward hit;
  - rX_busy excludes wb_stage_match.
- Undefined:
  - r1_fwd and r2_fwd ports are absent;
  - rX_busy includes wb_stage_match, which costs a 1-cycle stall on back-to-back dependence.

Decomposition:
- Shared package rv_regfile_pkg:
  - REG_ADDR_WIDTH=5, REG_DATA_WIDTH=32, NUM_REGS=32;
  - typedef wb_src_e {WB_ALU, WB_LSU};
  - packed struct wb_req_t {rd, data}.
- One sub-module: rr_arb2, a two-requester round-robin arbiter.
  - Ports: clk, rst, req[1:0], gnt[1:0].
  - Its pointer register is reset to ALU-first.

Test Plan:
- ALU only, x5=0x1234 -> alu_ready=1 same cycle; next cycle rf_write_en=1, rf_rd_addr=5, rf_rd_data=0x1234.
- ALU and LSU valid 3 consecutive cycles -> grants ALU, LSU, ALU.
- Issue load to x7 -> pending[7]=1 and r1_busy=1 for r1_addr=7. LSU returns x7=0xBEEF -> lsu_ready=1. Next cycle rf write. busy drops the cycle after (without bypass) or immediately with r1_fwd=1 (with bypass).
- Second issue to x7 while pending -> issue_stall=1 and no pending change. Same-cycle LSU clear of x9 and issue_long to x9 -> pending[9] stays 1.
- ALU valid rd=0 data=0xFFFF -> alu_ready=1, rf_write_en stays 0. r1_addr=0 -> r1_busy=0 always.
- Pending x3 plus in-flight write to x4, assert rst -> next cycle rf_write_en=0, all busy=0, ALU granted first on next contention.
